// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory-port arbiter     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 256;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter_if : both cache memory-side ports plus the memory port       |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
   parameter int LINE_W = mem_arb_pkg::DEF_LINE_W
) ();
   import mem_arb_pkg::*;

   logic              i_mem_enable_i;
   logic              i_mem_write_i;
   logic [ADDR_W-1:0] i_mem_addr_i;
   logic [LINE_W-1:0] i_mem_data_i;
   logic              i_mem_ack_o;

   logic              d_mem_enable_i;
   logic              d_mem_write_i;
   logic [ADDR_W-1:0] d_mem_addr_i;
   logic [LINE_W-1:0] d_mem_data_i;
   logic              d_mem_ack_o;

   logic [LINE_W-1:0] mem_rdata_o;
   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_data_o;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic              busy_o;

   // Arbiter side
   modport slave (
      input  i_mem_enable_i, i_mem_write_i, i_mem_addr_i, i_mem_data_i,
      input  d_mem_enable_i, d_mem_write_i, d_mem_addr_i, d_mem_data_i,
      input  mem_data_i, mem_ack_i,
      output i_mem_ack_o, d_mem_ack_o, mem_rdata_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, busy_o
   );

   // Caches and memory side
   modport master (
      output i_mem_enable_i, i_mem_write_i, i_mem_addr_i, i_mem_data_i,
      output d_mem_enable_i, d_mem_write_i, d_mem_addr_i, d_mem_data_i,
      output mem_data_i, mem_ack_i,
      input  i_mem_ack_o, d_mem_ack_o, mem_rdata_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, busy_o
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick2 : combinational two-way round-robin picker                      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rr_pick2
   import mem_arb_pkg::*;
(
   input  wire logic [1:0] req,
   input  wire logic       last,
   output logic            gnt_valid,
   output logic            gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = OWN_I;
      case (req)
         2'b01:   gnt_id = OWN_I;
         2'b10:   gnt_id = OWN_D;
         // Tie: the requester that was not served most recently wins
         2'b11:   gnt_id = (last == OWN_D) ? OWN_I : OWN_D;
         default: gnt_id = OWN_I;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : round-robin sharing of the line-wide memory port (I$/D$)   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  wire logic    clk_i,
   input  wire logic    rst_i,
   mem_arbiter_if.slave bus
);

   arb_state_e        r_state;
   logic              r_owner;
   logic              r_last;
   logic              r_mem_enable;
   logic              r_mem_write;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [LINE_W-1:0] r_mem_data;

   logic              w_gnt_valid;
   logic              w_gnt_id;
   logic              w_busy;
   logic              w_win_write;
   logic [ADDR_W-1:0] w_win_addr;
   logic [LINE_W-1:0] w_win_data;

   rr_pick2 u_pick (
      .req       ({bus.d_mem_enable_i, bus.i_mem_enable_i}),
      .last      (r_last),
      .gnt_valid (w_gnt_valid),
      .gnt_id    (w_gnt_id)
   );

   assign w_win_write = (w_gnt_id == OWN_D) ? bus.d_mem_write_i : bus.i_mem_write_i;
   assign w_win_addr  = (w_gnt_id == OWN_D) ? bus.d_mem_addr_i  : bus.i_mem_addr_i;
   assign w_win_data  = (w_gnt_id == OWN_D) ? bus.d_mem_data_i  : bus.i_mem_data_i;

   // Requester inputs are only looked at in IDLE, so a granted line stays frozen
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ARB_IDLE;
         r_owner      <= OWN_I;
         r_last       <= OWN_I;   // dcache wins the first tie
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_gnt_valid) begin
                  r_state      <= ARB_BUSY;
                  r_owner      <= w_gnt_id;
                  r_mem_enable <= 1'b1;
                  r_mem_write  <= w_win_write;
                  r_mem_addr   <= w_win_addr;
                  r_mem_data   <= w_win_data;
               end
            end
            ARB_BUSY: begin
               if (bus.mem_ack_i) begin
                  r_state      <= ARB_IDLE;
                  r_last       <= r_owner;
                  r_mem_enable <= 1'b0;
                  r_mem_write  <= 1'b0;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign w_busy = (r_state == ARB_BUSY);

   assign bus.i_mem_ack_o  = bus.mem_ack_i & w_busy & (r_owner == OWN_I);
   assign bus.d_mem_ack_o  = bus.mem_ack_i & w_busy & (r_owner == OWN_D);
   assign bus.mem_rdata_o  = bus.mem_data_i;
   assign bus.mem_enable_o = r_mem_enable;
   assign bus.mem_write_o  = r_mem_write;
   assign bus.mem_addr_o   = r_mem_addr;
   assign bus.mem_data_o   = r_mem_data;
   assign bus.busy_o       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter : directed + randomized bench with a transaction model    |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

   logic clk_i;
   logic rst_i;

   mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) u_bus ();

   mem_arbiter #(.ADDR_W(32), .LINE_W(256)) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (u_bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Stimulus for the next cycle
   logic         s_ie, s_iw, s_de, s_dw, s_ack;
   logic [31:0]  s_ia, s_da;
   logic [255:0] s_idat, s_ddat, s_rd;

   // Reference model: one line in flight, who holds it, who was served last
   bit           m_busy, m_owner, m_last, m_write;
   logic [31:0]  m_addr;
   logic [255:0] m_data;

   int n_chk, n_pass, n_iack, n_dack;
   bit acked, acked_owner, obs_i, obs_d;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_last = 0; m_write = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic zero_stim();
      s_ie = 0; s_iw = 0; s_de = 0; s_dw = 0; s_ack = 0;
      s_ia = '0; s_da = '0; s_idat = '0; s_ddat = '0; s_rd = '0;
      u_bus.i_mem_enable_i = 0; u_bus.i_mem_write_i = 0; u_bus.i_mem_addr_i = '0; u_bus.i_mem_data_i = '0;
      u_bus.d_mem_enable_i = 0; u_bus.d_mem_write_i = 0; u_bus.d_mem_addr_i = '0; u_bus.d_mem_data_i = '0;
      u_bus.mem_ack_i = 0; u_bus.mem_data_i = '0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},   256'(u_bus.busy_o),       256'(0));
      check({tag, "_enable"}, 256'(u_bus.mem_enable_o), 256'(0));
      check({tag, "_write"},  256'(u_bus.mem_write_o),  256'(0));
      check({tag, "_addr"},   256'(u_bus.mem_addr_o),   256'(0));
      check({tag, "_data"},   u_bus.mem_data_o,         256'(0));
      check({tag, "_iack"},   256'(u_bus.i_mem_ack_o),  256'(0));
      check({tag, "_dack"},   256'(u_bus.d_mem_ack_o),  256'(0));
   endtask

   // Reset asserted between clock edges; outputs must drop without a clock
   task automatic async_reset(input string tag);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      zero_stim();
      #1;
      check_idle_outputs(tag);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // One clock: apply stimulus, check forwarded acks, advance model, check registers
   task automatic cycle();
      bit fwd;
      @(negedge clk_i);
      u_bus.i_mem_enable_i = s_ie; u_bus.i_mem_write_i = s_iw;
      u_bus.i_mem_addr_i   = s_ia; u_bus.i_mem_data_i  = s_idat;
      u_bus.d_mem_enable_i = s_de; u_bus.d_mem_write_i = s_dw;
      u_bus.d_mem_addr_i   = s_da; u_bus.d_mem_data_i  = s_ddat;
      u_bus.mem_ack_i      = s_ack; u_bus.mem_data_i   = s_rd;
      #1;
      fwd = s_ack && m_busy;
      obs_i = (u_bus.i_mem_ack_o === 1'b1);
      obs_d = (u_bus.d_mem_ack_o === 1'b1);
      check("i_ack", 256'(u_bus.i_mem_ack_o), 256'(fwd && !m_owner));
      check("d_ack", 256'(u_bus.d_mem_ack_o), 256'(fwd && m_owner));
      if (fwd) check("rdata", u_bus.mem_rdata_o, s_rd);
      if (obs_i) n_iack++;
      if (obs_d) n_dack++;
      acked = fwd;
      acked_owner = m_owner;
      if (m_busy) begin
         if (s_ack) begin
            m_busy = 0; m_write = 0; m_last = m_owner;
         end
      end else if (s_ie || s_de) begin
         m_owner = (s_ie && s_de) ? !m_last : s_de;
         m_busy  = 1;
         m_write = m_owner ? s_dw : s_iw;
         m_addr  = m_owner ? s_da : s_ia;
         m_data  = m_owner ? s_ddat : s_idat;
      end
      @(posedge clk_i);
      #1;
      check("busy",       256'(u_bus.busy_o),       256'(m_busy));
      check("mem_enable", 256'(u_bus.mem_enable_o), 256'(m_busy));
      check("mem_write",  256'(u_bus.mem_write_o),  256'(m_write));
      check("mem_addr",   256'(u_bus.mem_addr_o),   256'(m_addr));
      check("mem_data",   u_bus.mem_data_o,         m_data);
   endtask

   initial begin
      bit ip, dp, was_busy;
      int lat, i0, d0;
      logic [255:0] a5;
      n_chk = 0; n_pass = 0; n_iack = 0; n_dack = 0; lat = 0;
      a5 = {32{8'hA5}};
      rst_i = 1'b1;
      zero_stim();
      model_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      check_idle_outputs("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Single dcache read, memory answers ten cycles after the grant
      i0 = n_iack; d0 = n_dack;
      s_de = 1; s_dw = 0; s_da = 32'h0000_0400; s_ddat = {8{32'h1234_5678}};
      cycle();
      check("t1_addr",  256'(u_bus.mem_addr_o),  256'(32'h400));
      check("t1_write", 256'(u_bus.mem_write_o), 256'(0));
      for (int k = 0; k < 9; k++) cycle();
      s_ack = 1; s_rd = a5;
      cycle();
      check("t1_rdata", u_bus.mem_rdata_o, a5);
      s_ack = 0; s_de = 0;
      cycle();
      check("t1_dack_count", 256'(n_dack - d0), 256'(1));
      check("t1_iack_count", 256'(n_iack - i0), 256'(0));

      // Tie straight after reset: dcache write first, then icache read
      async_reset("rst_t2");
      s_ie = 1; s_iw = 0; s_ia = 32'h100; s_idat = {8{32'hCAFE_0001}};
      s_de = 1; s_dw = 1; s_da = 32'h200; s_ddat = {8{32'hDEAD_BEEF}};
      cycle();
      check("t2_first_addr",  256'(u_bus.mem_addr_o),  256'(32'h200));
      check("t2_first_write", 256'(u_bus.mem_write_o), 256'(1));
      cycle(); cycle();
      s_ack = 1; s_rd = {8{32'h0BAD_F00D}};
      cycle();
      check("t2_first_dack", 256'(obs_d), 256'(1));
      s_ack = 0; s_de = 0;
      cycle();
      check("t2_second_addr",  256'(u_bus.mem_addr_o),  256'(32'h100));
      check("t2_second_write", 256'(u_bus.mem_write_o), 256'(0));
      // Address changes mid-transaction must not reach memory
      s_ia = 32'h300;
      cycle(); cycle();
      check("t4_addr_frozen", 256'(u_bus.mem_addr_o), 256'(32'h100));
      s_ack = 1;
      cycle();
      check("t2_second_iack", 256'(obs_i), 256'(1));
      s_ack = 0;

      // Both requesting continuously: D, I, D, I, D, I
      s_ie = 1; s_ia = 32'h100; s_de = 1; s_da = 32'h200; s_dw = 0;
      for (int k = 0; k < 6; k++) begin
         s_ack = 0;
         cycle();
         cycle();
         s_ack = 1; s_rd = {8{$urandom}};
         cycle();
         check("alt_dack", 256'(obs_d), 256'(k % 2 == 0));
         check("alt_iack", 256'(obs_i), 256'(k % 2 == 1));
      end
      s_ack = 0; s_ie = 0; s_de = 0;
      cycle();

      // Reset three cycles into a transaction, then a stale ack
      s_ie = 1; s_ia = 32'h180; s_iw = 1;
      cycle();
      cycle(); cycle(); cycle();
      async_reset("rst_mid");
      i0 = n_iack; d0 = n_dack;
      s_ack = 1; s_rd = a5;
      cycle();
      s_ack = 0;
      cycle();
      check("stale_ack_count", 256'(n_iack + n_dack - i0 - d0), 256'(0));

      // Spurious ack while idle must not disturb the tie order
      s_ack = 1;
      cycle();
      check("spurious_busy", 256'(u_bus.busy_o), 256'(0));
      s_ack = 0;
      s_ie = 1; s_ia = 32'h111; s_de = 1; s_da = 32'h222;
      cycle();
      check("spurious_tie_addr", 256'(u_bus.mem_addr_o), 256'(32'h222));
      s_ack = 1;
      cycle();
      s_ack = 0; s_ie = 0; s_de = 0;
      cycle();

      // Randomized traffic against the model
      ip = 0; dp = 0;
      for (int c = 0; c < 600; c++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; s_ia = $urandom; s_iw = 1'($urandom_range(0, 1)); s_idat = {8{$urandom}};
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; s_da = $urandom; s_dw = 1'($urandom_range(0, 1)); s_ddat = {8{$urandom}};
         end
         s_ie = ip; s_de = dp;
         if (m_busy) begin
            if (!m_owner && $urandom_range(0, 3) == 0) begin s_ia = $urandom; s_idat = {8{$urandom}}; end
            if (m_owner && $urandom_range(0, 3) == 0)  begin s_da = $urandom; s_ddat = {8{$urandom}}; end
            s_ack = (lat == 0);
            if (lat > 0) lat--;
         end else begin
            s_ack = ($urandom_range(0, 7) == 0);
         end
         s_rd = {8{$urandom}};
         was_busy = m_busy;
         cycle();
         if (acked) begin
            if (acked_owner) dp = 0;
            else ip = 0;
         end
         if (!was_busy && m_busy) lat = $urandom_range(0, 4);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
